// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest datapath the saturation helpers can describe.
  localparam int SAT_MAX_W = 256;

  function automatic int cla_stages(input int width, input int block);
    return (width / block < 1) ? 1 : width / block;
  endfunction

  // Most positive two's-complement value of the given width: 0111...1
  function automatic logic [SAT_MAX_W-1:0] sat_pos(input int width);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++)
      if (i < width - 1) r[i] = 1'b1;
    return r;
  endfunction

  // Most negative two's-complement value of the given width: 1000...0
  function automatic logic [SAT_MAX_W-1:0] sat_neg(input int width);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++)
      if (i == width - 1) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_block.sv
// Combinational BLOCK-bit carry-lookahead slice; every carry is a flat
// generate/propagate sum-of-products from cin.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] g, p;
  logic [BLOCK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic acc, term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      acc = cin;
      for (int j = 0; j <= i; j++) acc = acc & p[j];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign sum   = p ^ c[BLOCK-1:0];
  assign cout  = c[BLOCK];
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// WIDTH-bit signed add/subtract, one BLOCK-bit lookahead slice per stage.
// Define CLA_SATURATE_EN to clamp the result to the signed extreme on overflow.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             carry_out
);

  localparam int STAGES = cla_stages(WIDTH, BLOCK);

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic                         ovf_q, ovf_d;

  // Index 0 is the input port side; index k+1 is the register after stage k.
  logic [STAGES:0][WIDTH-1:0]   src_a, src_b, src_s;
  logic [STAGES:0]              src_c, src_v;
  logic [WIDTH-1:0]             b_eff;

  logic [STAGES-1:0][BLOCK-1:0] blk_sum;
  logic [STAGES-1:0]            blk_cout, blk_cmsb;

  logic stall;

  assign stall    = vld_q[STAGES-1] && !out_ready;
  assign in_ready = !stall;

  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign src_a = {a_q, a};
  assign src_b = {b_q, b_eff};
  assign src_s = {s_q, {WIDTH{1'b0}}};
  assign src_c = {c_q, op};
  assign src_v = {vld_q, in_valid};

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    cla_block #(.BLOCK(BLOCK)) u_blk (
      .a     (src_a[k][k*BLOCK +: BLOCK]),
      .b     (src_b[k][k*BLOCK +: BLOCK]),
      .cin   (src_c[k]),
      .sum   (blk_sum[k]),
      .cout  (blk_cout[k]),
      .c_msb (blk_cmsb[k])
    );
  end

`ifdef CLA_SATURATE_EN
  localparam logic [SAT_MAX_W-1:0] SAT_POS_W = sat_pos(WIDTH);
  localparam logic [SAT_MAX_W-1:0] SAT_NEG_W = sat_neg(WIDTH);
`endif

  always_comb begin
    vld_d = '0;
    c_d   = '0;
    a_d   = '0;
    b_d   = '0;
    s_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = src_v[k];
      a_d[k]   = src_a[k];
      b_d[k]   = src_b[k];
      s_d[k]   = src_s[k];
      s_d[k][k*BLOCK +: BLOCK] = blk_sum[k];
      c_d[k]   = blk_cout[k];
    end
    ovf_d = blk_cmsb[STAGES-1] ^ blk_cout[STAGES-1];
`ifdef CLA_SATURATE_EN
    // Overflow implies both operands share a sign, so a's MSB picks the rail.
    if (ovf_d)
      s_d[STAGES-1] = src_a[STAGES-1][WIDTH-1] ? SAT_NEG_W[WIDTH-1:0]
                                               : SAT_POS_W[WIDTH-1:0];
`endif
  end

  // A stall freezes every stage, bubbles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  end

  // Last-stage operand copies only exist to keep the skew chain uniform.
  logic unused_skew;
  assign unused_skew = ^{src_a[STAGES], src_b[STAGES]};

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign overflow  = ovf_q;
  assign carry_out = c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed-vector bench for pipelined_cla_addsub at WIDTH=16, BLOCK=4.
module tb_pipelined_cla_addsub;

  localparam int WIDTH = 16;
  localparam int BLOCK = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             op = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic             carry_out;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  // Offers one beat and waits for its result; reports latency in accept cycles.
  task automatic run_beat(input logic [15:0] ta, input logic [15:0] tb_v, input logic top,
                          output logic [15:0] rs, output logic rovf, output logic rcout,
                          output int lat);
    @(negedge clk);
    a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rs = sum; rovf = overflow; rcout = carry_out;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (sum !== 16'h0000) $display("FAIL rst_sum got %h exp 0000", sum); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b exp 0", overflow); else pass_cnt++;
    chk_cnt++; if (carry_out !== 1'b0) $display("FAIL rst_carry_out got %b exp 0", carry_out); else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_add();
    logic [15:0] s; logic v, c; int lat;
    run_beat(16'd13, 16'd12, 1'b0, s, v, c, lat);
    chk_cnt++; if (lat !== 4) $display("FAIL add_latency got %0d exp 4", lat); else pass_cnt++;
    chk_cnt++; if (s !== 16'd25) $display("FAIL add_sum got %h exp 0019", s); else pass_cnt++;
    chk_cnt++; if (v !== 1'b0) $display("FAIL add_overflow got %b exp 0", v); else pass_cnt++;
    chk_cnt++; if (c !== 1'b0) $display("FAIL add_carry got %b exp 0", c); else pass_cnt++;
  endtask

  task automatic test_sub();
    logic [15:0] s; logic v, c; int lat;
    // 13 - (-12): 0x000D + 0x000B + 1 = 0x0019, unsigned borrow -> carry 0
    run_beat(16'd13, 16'hFFF4, 1'b1, s, v, c, lat);
    chk_cnt++; if (s !== 16'd25) $display("FAIL sub_sum got %h exp 0019", s); else pass_cnt++;
    chk_cnt++; if (v !== 1'b0) $display("FAIL sub_overflow got %b exp 0", v); else pass_cnt++;
    chk_cnt++; if (c !== 1'b0) $display("FAIL sub_carry got %b exp 0", c); else pass_cnt++;
  endtask

  task automatic test_carry_ripple();
    logic [15:0] s; logic v, c; int lat;
    run_beat(16'hFFFF, 16'h0001, 1'b0, s, v, c, lat);
    chk_cnt++; if (s !== 16'h0000) $display("FAIL ripple_sum got %h exp 0000", s); else pass_cnt++;
    chk_cnt++; if (c !== 1'b1) $display("FAIL ripple_carry got %b exp 1", c); else pass_cnt++;
    chk_cnt++; if (v !== 1'b0) $display("FAIL ripple_overflow got %b exp 0", v); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [15:0] s, exp_pos, exp_neg; logic v, c; int lat;
`ifdef CLA_SATURATE_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_pos = 16'h8000; exp_neg = 16'h7FFF;
`endif
    run_beat(16'h7FFF, 16'h0001, 1'b0, s, v, c, lat);
    chk_cnt++; if (v !== 1'b1) $display("FAIL posovf_flag got %b exp 1", v); else pass_cnt++;
    chk_cnt++; if (s !== exp_pos) $display("FAIL posovf_sum got %h exp %h", s, exp_pos); else pass_cnt++;
    chk_cnt++; if (c !== 1'b0) $display("FAIL posovf_carry got %b exp 0", c); else pass_cnt++;
    // 0x8000 + 0xFFFE + 1 = 0x1_7FFF
    run_beat(16'h8000, 16'h0001, 1'b1, s, v, c, lat);
    chk_cnt++; if (v !== 1'b1) $display("FAIL negovf_flag got %b exp 1", v); else pass_cnt++;
    chk_cnt++; if (s !== exp_neg) $display("FAIL negovf_sum got %h exp %h", s, exp_neg); else pass_cnt++;
    chk_cnt++; if (c !== 1'b1) $display("FAIL negovf_carry got %b exp 1", c); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int got = 0, first = -1, last = -1;
    logic [15:0] exp;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        exp = 16'(2 * got);
        chk_cnt++; if (sum !== exp) $display("FAIL b2b_sum[%0d] got %h exp %h", got, sum, exp); else pass_cnt++;
        got++;
      end
      if (cyc < 8) begin
        in_valid = 1'b1; a = 16'(cyc); b = 16'(cyc); op = 1'b0;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc %0d got %b exp 1", cyc, in_ready); else pass_cnt++;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk_cnt++; if (got !== 8) $display("FAIL b2b_count got %0d exp 8", got); else pass_cnt++;
    chk_cnt++; if (first !== 4) $display("FAIL b2b_first_cycle got %0d exp 4", first); else pass_cnt++;
    chk_cnt++; if (last - first !== 7) $display("FAIL b2b_contiguous got %0d exp 7", last - first); else pass_cnt++;
  endtask

  task automatic test_stall();
    int idx = 0, got = 0;
    logic [15:0] held = '0, exp;
    logic acc, exp_rdy;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (idx < 8) begin
        in_valid = 1'b1; a = 16'(16 * idx); b = 16'd3; op = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = !(cyc >= 6 && cyc <= 8);
      chk_cnt++; if (in_ready !== exp_rdy) $display("FAIL stall_in_ready cyc %0d got %b exp %b", cyc, in_ready, exp_rdy); else pass_cnt++;
      if (out_valid && out_ready) begin
        exp = 16'(16 * got + 3);
        chk_cnt++; if (sum !== exp) $display("FAIL stall_sum[%0d] got %h exp %h", got, sum, exp); else pass_cnt++;
        got++;
      end
      if (out_valid && !out_ready) begin
        if (cyc == 6) held = sum;
        else begin
          chk_cnt++; if (sum !== held) $display("FAIL stall_hold cyc %0d got %h exp %h", cyc, sum, held); else pass_cnt++;
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    chk_cnt++; if (got !== 8) $display("FAIL stall_count got %0d exp 8", got); else pass_cnt++;
    chk_cnt++; if (held !== 16'h0023) $display("FAIL stall_held_beat got %h exp 0023", held); else pass_cnt++;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_inflight();
    logic [15:0] s; logic v, c; int lat, stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'(1000 * (i + 1)); b = 16'd1; op = 1'b0;
    end
    #1;
    chk_cnt++; if (!(out_valid === 1'b1 && sum === 16'd1001)) $display("FAIL rstfly_pre got %b/%h exp 1/03e9", out_valid, sum); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rstfly_out_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (sum !== 16'h0000) $display("FAIL rstfly_sum got %h exp 0000", sum); else pass_cnt++;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_beat(16'd5, 16'd6, 1'b0, s, v, c, lat);
    chk_cnt++; if (lat !== 4) $display("FAIL rstfly_latency got %0d exp 4", lat); else pass_cnt++;
    chk_cnt++; if (s !== 16'd11) $display("FAIL rstfly_sum_after got %h exp 000b", s); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk_cnt++; if (stale !== 0) $display("FAIL rstfly_stale got %0d exp 0", stale); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry_ripple();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
